mm_throttle_multi: RTL and testbench

- Parametrised multi-channel step-interval throttle for the motor-drive FPGA.
- Generates its own microsecond tick from the 16 MHz system clock; no separate 1 MHz clock input.
- Each channel independently times a per-step interval with start, abort and optional auto-reload.
- Sits between the per-motor state machines and the step pulse generators, telling each motor state machine when its current step period has elapsed.

---
 rtl/mm_throttle_multi_pkg.sv | 13 +
 rtl/mm_throttle_multi_chan.sv | 84 ++++++++
 rtl/mm_throttle_multi.sv | 62 ++++++
 tb/tb_mm_throttle_multi.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_throttle_multi_pkg.sv
// Shared types for the multi-channel step-interval throttle.
package mm_throttle_multi_pkg;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_t;

  localparam int DEF_CNT_W = 32;

  typedef logic [DEF_CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mm_throttle_multi_chan.sv
// One throttle channel: step-length down-counter, IDLE/RUN state and expire pulse.
// Optional sticky retrigger flag under MM_THROTTLE_OVERRUN_EN.
//
// state   | meaning
// CH_IDLE | count == 0, done = 1, ticks ignored
// CH_RUN  | count > 0, decrements on each tick
module mm_throttle_chan
  import mm_throttle_multi_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clock_16mhz,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             abort,
  input  logic             reload,
  input  logic [CNT_W-1:0] step_len,
  output logic             done,
  output logic             expire
`ifdef MM_THROTTLE_OVERRUN_EN
  ,
  output logic             overrun,
  input  logic             overrun_clr
`endif
);

  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             expire_nxt;

  always_ff @(posedge clock_16mhz) begin
    if (reset) begin
      state  <= CH_IDLE;
      cnt    <= '0;
      expire <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      expire <= expire_nxt;
    end
  end

  // Priority: abort, start, then tick; a tick coinciding with start is dropped.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    expire_nxt = 1'b0;
    if (abort) begin
      state_nxt = CH_IDLE;
      cnt_nxt   = '0;
    end else if (start) begin
      cnt_nxt   = step_len;
      state_nxt = (step_len != '0) ? CH_RUN : CH_IDLE;
    end else if (tick && state == CH_RUN) begin
      if (cnt == CNT_W'(1)) begin
        expire_nxt = 1'b1;
        if (reload && step_len != '0) begin
          cnt_nxt = step_len;
        end else begin
          cnt_nxt   = '0;
          state_nxt = CH_IDLE;
        end
      end else begin
        cnt_nxt = cnt - CNT_W'(1);
      end
    end
  end

  assign done = (state == CH_IDLE);

`ifdef MM_THROTTLE_OVERRUN_EN
  always_ff @(posedge clock_16mhz) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (start && !abort && state == CH_RUN) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/mm_throttle_multi.sv
// Multi-channel step-interval throttle with a shared free-running tick prescaler.
// Define MM_THROTTLE_OVERRUN_EN to add per-channel sticky retrigger flags.
module mm_throttle_multi
  import mm_throttle_multi_pkg::*;
#(
  parameter int N_CHAN   = 2,
  parameter int CNT_W    = 32,
  parameter int TICK_DIV = 16
) (
  input  logic                    clock_16mhz,
  input  logic                    reset,
  input  logic [N_CHAN-1:0]       start,
  input  logic [N_CHAN-1:0]       abort,
  input  logic [N_CHAN-1:0]       reload,
  input  logic [N_CHAN*CNT_W-1:0] step_len,
  output logic [N_CHAN-1:0]       done,
  output logic [N_CHAN-1:0]       expire,
  output logic                    tick
`ifdef MM_THROTTLE_OVERRUN_EN
  ,
  output logic [N_CHAN-1:0]       overrun,
  input  logic [N_CHAN-1:0]       overrun_clr
`endif
);

  localparam int              PRE_W    = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] presc;

  always_ff @(posedge clock_16mhz) begin
    if (reset) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (presc == PRE_LAST);
      presc <= (presc == PRE_LAST) ? '0 : presc + PRE_W'(1);
    end
  end

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    mm_throttle_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clock_16mhz(clock_16mhz),
      .reset      (reset),
      .tick       (tick),
      .start      (start[i]),
      .abort      (abort[i]),
      .reload     (reload[i]),
      .step_len   (step_len[i*CNT_W +: CNT_W]),
      .done       (done[i]),
      .expire     (expire[i])
`ifdef MM_THROTTLE_OVERRUN_EN
      ,
      .overrun    (overrun[i]),
      .overrun_clr(overrun_clr[i])
`endif
    );
  end

endmodule

// File: tb/tb_mm_throttle_multi.sv
// Bench for mm_throttle_multi: directed scenarios plus random traffic vs a count-level model.
module tb_mm_throttle_multi;

  localparam int N = 2;
  localparam int W = 32;
  localparam int D = 16;

  logic           clock_16mhz = 1'b0;
  logic           reset       = 1'b1;
  logic [N-1:0]   start       = '0;
  logic [N-1:0]   abort       = '0;
  logic [N-1:0]   reload      = '0;
  logic [N*W-1:0] step_len    = '0;
  logic [N-1:0]   done;
  logic [N-1:0]   expire;
  logic           tick;
`ifdef MM_THROTTLE_OVERRUN_EN
  logic [N-1:0]   overrun;
  logic [N-1:0]   overrun_clr = '0;
`endif

  mm_throttle_multi #(.N_CHAN(N), .CNT_W(W), .TICK_DIV(D)) dut (
    .clock_16mhz(clock_16mhz),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .reload     (reload),
    .step_len   (step_len),
    .done       (done),
    .expire     (expire),
    .tick       (tick)
`ifdef MM_THROTTLE_OVERRUN_EN
    ,
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
`endif
  );

  always #5 clock_16mhz = ~clock_16mhz;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain remaining-tick counts, tick from cycle phase.
  longint unsigned m_cnt[N];
  logic [N-1:0]    m_exp;
  logic [N-1:0]    m_ovr;
  logic            m_tick;
  int              m_phase;
  bit              m_valid = 0;

  always @(posedge clock_16mhz) begin
    if (reset) begin
      m_phase = 0;
      m_tick  = 1'b0;
      m_exp   = '0;
      m_ovr   = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_valid = 1;
    end else if (m_valid) begin
      for (int i = 0; i < N; i++) begin
        longint unsigned sl;
        sl = longint'(step_len[i*W +: W]);
        m_exp[i] = 1'b0;
        if (abort[i]) begin
          m_cnt[i] = 0;
`ifdef MM_THROTTLE_OVERRUN_EN
          if (overrun_clr[i]) m_ovr[i] = 1'b0;
`endif
        end else if (start[i]) begin
          if (m_cnt[i] > 0) m_ovr[i] = 1'b1;
`ifdef MM_THROTTLE_OVERRUN_EN
          else if (overrun_clr[i]) m_ovr[i] = 1'b0;
`endif
          m_cnt[i] = sl;
        end else begin
`ifdef MM_THROTTLE_OVERRUN_EN
          if (overrun_clr[i]) m_ovr[i] = 1'b0;
`endif
          if (m_tick && m_cnt[i] > 0) begin
            if (m_cnt[i] == 1) begin
              m_exp[i] = 1'b1;
              m_cnt[i] = reload[i] ? sl : 0;
            end else begin
              m_cnt[i] = m_cnt[i] - 1;
            end
          end
        end
      end
      m_tick  = (m_phase == D - 1);
      m_phase = (m_phase + 1) % D;
    end
  end

  always @(negedge clock_16mhz) begin
    if (m_valid) begin
      logic [N-1:0] exp_done;
      for (int i = 0; i < N; i++) exp_done[i] = (m_cnt[i] == 0);
      chk("done",   64'(done),   64'(exp_done));
      chk("expire", 64'(expire), 64'(m_exp));
      chk("tick",   64'(tick),   64'(m_tick));
`ifdef MM_THROTTLE_OVERRUN_EN
      chk("overrun", 64'(overrun), 64'(m_ovr));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock_16mhz);
  endtask

  int exp_seen;

  // Advance until a tick is visible (it is applied at the following edge).
  task automatic wait_tick(input int ch);
    bit ok;
    ok = 0;
    for (int g = 0; g < 3 * D; g++) begin
      if (expire[ch]) exp_seen++;
      if (tick) begin
        ok = 1;
        break;
      end
      @(negedge clock_16mhz);
    end
    chk("tick_wait_bound", 64'(ok), 64'd1);
  endtask

  task automatic set_len(input int ch, input int v);
    step_len[ch*W +: W] = W'(v);
  endtask

  initial begin
    int tc, ne, first, guard;
    bit ok;

    // Reset then idle
    cyc(3);
    reset = 1'b0;
    tc = 0;
    repeat (100) begin
      @(negedge clock_16mhz);
      if (tick) tc++;
    end
    chk("idle_ticks", 64'(tc), 64'd6);
    chk("idle_done", 64'(done), 64'(2'b11));

    // One-shot, step_len 3
    set_len(0, 3);
    start[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
    chk("oneshot_done_low", 64'(done[0]), 64'd0);
    ne = 0;
    first = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge clock_16mhz);
      if (expire[0]) begin
        ne++;
        if (first == 0) first = c;
      end
    end
    chk("oneshot_expires", 64'(ne), 64'd1);
    chk("oneshot_interval_in_33_48", 64'(first >= 33 && first <= 48), 64'd1);
    chk("oneshot_done_high", 64'(done[0]), 64'd1);

    // Periodic, step_len 2, ten ticks
    set_len(1, 2);
    reload[1] = 1'b1;
    start[1] = 1'b1;
    cyc(1);
    start[1] = 1'b0;
    tc = 0;
    ne = 0;
    ok = 1;
    guard = 0;
    while (tc < 10 && guard < 400) begin
      if (expire[1]) ne++;
      if (done[1] !== 1'b0) ok = 0;
      if (tick) tc++;
      guard++;
      @(negedge clock_16mhz);
    end
    if (expire[1]) ne++;
    chk("periodic_bound", 64'(guard < 400), 64'd1);
    chk("periodic_expires", 64'(ne), 64'd5);
    chk("periodic_done_low", 64'(ok & ~done[1]), 64'd1);
    abort[1] = 1'b1;
    cyc(1);
    abort[1] = 1'b0;
    reload[1] = 1'b0;
    chk("abort_done", 64'(done[1]), 64'd1);
    ne = 0;
    repeat (40) begin
      @(negedge clock_16mhz);
      if (expire[1]) ne++;
    end
    chk("abort_no_expire", 64'(ne), 64'd0);

    // Zero length start, then start+abort together
    set_len(0, 0);
    start[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
    chk("zero_len_done", 64'(done[0]), 64'd1);
    ne = 0;
    repeat (40) begin
      @(negedge clock_16mhz);
      if (expire[0]) ne++;
    end
    chk("zero_len_no_expire", 64'(ne), 64'd0);
    set_len(0, 5);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    chk("start_abort_done", 64'(done[0]), 64'd1);

    // Retrigger after two ticks: expiry on the 7th tick overall
    start[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
    exp_seen = 0;
    wait_tick(0);
    cyc(1);
    wait_tick(0);
    cyc(1);
    start[0] = 1'b1;
    cyc(1);
    start[0] = 1'b0;
`ifdef MM_THROTTLE_OVERRUN_EN
    chk("overrun_set", 64'(overrun[0]), 64'd1);
`endif
    for (int k = 0; k < 4; k++) begin
      wait_tick(0);
      cyc(1);
    end
    chk("retrig_no_early_expire", 64'(exp_seen), 64'd0);
    chk("retrig_running", 64'(done[0]), 64'd0);
    wait_tick(0);
    cyc(1);
    chk("retrig_expire_7th", 64'(expire[0]), 64'd1);
`ifdef MM_THROTTLE_OVERRUN_EN
    chk("overrun_sticky", 64'(overrun[0]), 64'd1);
    overrun_clr[0] = 1'b1;
    cyc(1);
    overrun_clr[0] = 1'b0;
    chk("overrun_cleared", 64'(overrun[0]), 64'd0);
`endif

    // Reset mid-run on both channels, with a start in the same cycle
    set_len(0, 4);
    set_len(1, 4);
    reload = 2'b11;
    start = 2'b11;
    cyc(1);
    start = 2'b00;
    cyc(20);
    chk("both_running", 64'(done), 64'd0);
    reset = 1'b1;
    start = 2'b11;
    cyc(1);
    reset = 1'b0;
    start = 2'b00;
    chk("reset_done", 64'(done), 64'(2'b11));
    chk("reset_expire", 64'(expire), 64'd0);
    chk("reset_tick", 64'(tick), 64'd0);
    reload = 2'b00;
    cyc(20);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++) begin
        start[i]  = ($urandom_range(0, 40) == 0);
        abort[i]  = ($urandom_range(0, 120) == 0);
        if ($urandom_range(0, 60) == 0) reload[i] = ~reload[i];
        if ($urandom_range(0, 10) == 0) set_len(i, int'($urandom_range(0, 5)));
`ifdef MM_THROTTLE_OVERRUN_EN
        overrun_clr[i] = ($urandom_range(0, 50) == 0);
`endif
      end
      reset = ($urandom_range(0, 700) == 0);
      cyc(1);
    end
    start = '0;
    abort = '0;
    reset = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
